bcd_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_digit.sv | 38 +++
 rtl/bcd_counter.sv | 108 ++++++++++
 tb/tb_bcd_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and digit helper functions.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

   // Force an out-of-range nibble (A..F) down to the largest legal digit.
   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      bcd_digit_t r;
      r = (d > BCD_MAX) ? BCD_MAX : d;
      return r;
   endfunction

   // True when a nibble is not a legal BCD digit.
   function automatic logic bcd_invalid(input bcd_digit_t d);
      return (d > BCD_MAX);
   endfunction

   // Next digit value in the selected direction, wrapping 9->0 / 0->9.
   function automatic bcd_digit_t bcd_next(input bcd_digit_t d, input logic up);
      bcd_digit_t r;
      if (up) begin
         r = (d == BCD_MAX) ? BCD_MIN : d + bcd_digit_t'(1);
      end else begin
         r = (d == BCD_MIN) ? BCD_MAX : d - bcd_digit_t'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one registered BCD digit with carry/borrow chaining.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step_in,
   input  logic       up,
   input  logic       load,
   input  bcd_digit_t load_digit,
   output bcd_digit_t digit,
   output logic       step_out
);

   logic       at_edge;
   bcd_digit_t digit_nxt;

   // Boundary detect, carry/borrow out and the stepped value.
   always_comb begin
      at_edge   = 1'b0;
      digit_nxt = digit;
      at_edge   = up ? (digit == BCD_MAX) : (digit == BCD_MIN);
      digit_nxt = bcd_next(digit, up);
      step_out  = step_in & at_edge;
   end

   // Digit register: reset, then clamped load, then step.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= BCD_MIN;
      end else if (load) begin
         digit <= bcd_clamp(load_digit);
      end else if (step_in) begin
         digit <= digit_nxt;
      end
   end

endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD up/down counter with prescaler, parallel load,
// terminal-count pulse and load-error pulse.
// Build option: BCD_COUNTER_SAT_EN selects saturating instead of wrapping
// behaviour at all-9s (up) / all-0s (down).
module bcd_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned PRESCALE = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tc,
   output logic                  load_err
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

   logic [PW-1:0]   pcnt;
   logic            step_c;
   logic            chain_in_c;
   logic            tc_nxt_c;
   logic            bad_nibble_c;
   logic [DIGITS:0] carry;

   // A count step fires on the last enabled prescaler cycle, never during load.
   always_comb begin
      step_c = en & ~load & (pcnt == PLAST);
   end

   // Prescaler phase: cleared by reset and load, advances only when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
      end else if (load) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
      end
   end

`ifdef BCD_COUNTER_SAT_EN
   logic all_max_c;
   logic all_min_c;
   logic sat_c;

   // Saturation: block the step at the range end but still report it as tc.
   always_comb begin
      all_max_c = 1'b1;
      all_min_c = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd[4*i +: 4] != BCD_MAX) all_max_c = 1'b0;
         if (bcd[4*i +: 4] != BCD_MIN) all_min_c = 1'b0;
      end
      sat_c      = up ? all_max_c : all_min_c;
      chain_in_c = step_c & ~sat_c;
      tc_nxt_c   = (step_c & sat_c) | carry[DIGITS];
   end
`else
   // Wrap mode: tc is the carry/borrow falling out of the top digit.
   always_comb begin
      chain_in_c = step_c;
      tc_nxt_c   = carry[DIGITS];
   end
`endif

   assign carry[0] = chain_in_c;

   // Ripple chain of digit registers, digit 0 in the LSBs.
   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
      bcd_digit u_digit (
         .clk        (clk),
         .rst        (rst),
         .step_in    (carry[g]),
         .up         (up),
         .load       (load),
         .load_digit (load_val[4*g +: 4]),
         .digit      (bcd[4*g +: 4]),
         .step_out   (carry[g+1])
      );
   end

   // Any load nibble above 9 is flagged; the digits clamp it themselves.
   always_comb begin
      bad_nibble_c = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_invalid(load_val[4*i +: 4])) bad_nibble_c = 1'b1;
      end
   end

   // Single-cycle status pulses, aligned with the bcd value they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         tc       <= 1'b0;
         load_err <= 1'b0;
      end else begin
         tc       <= tc_nxt_c;
         load_err <= load & bad_nibble_c;
      end
   end

endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed table plus hand sequences for two instances
// (PRESCALE=1 and PRESCALE=3, both DIGITS=2).
module tb_bcd_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, up_a, load_a;
   logic [7:0] lv_a, bcd_a;
   logic       tc_a, err_a;
   logic       en_b, up_b, load_b;
   logic [7:0] lv_b, bcd_b;
   logic       tc_b, err_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_counter #(.DIGITS(2), .PRESCALE(1)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a),
      .load_val(lv_a), .bcd(bcd_a), .tc(tc_a), .load_err(err_a)
   );

   bcd_counter #(.DIGITS(2), .PRESCALE(3)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b),
      .load_val(lv_b), .bcd(bcd_b), .tc(tc_b), .load_err(err_b)
   );

   typedef struct {
      logic       rst;
      logic       load;
      logic       en;
      logic       up;
      logic [7:0] lv;
      logic [7:0] bcd;
      logic       tc;
      logic       err;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [7:0] got_bcd, input logic got_tc,
                      input logic got_err, input logic [7:0] exp_bcd, input logic exp_tc,
                      input logic exp_err);
      n_cmp++;
      if (got_bcd !== exp_bcd || got_tc !== exp_tc || got_err !== exp_err) begin
         n_bad++;
         $display("FAIL %s: got bcd=%h tc=%b err=%b, expected bcd=%h tc=%b err=%b",
                  name, got_bcd, got_tc, got_err, exp_bcd, exp_tc, exp_err);
      end
   endtask

   // Drive instance A for one clock, then sample 1 time unit after the edge.
   task automatic cyc_a(input logic r, input logic ld, input logic e, input logic u,
                        input logic [7:0] v);
      rst = r; load_a = ld; en_a = e; up_a = u; lv_a = v;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_b(input logic ld, input logic e, input logic [7:0] v);
      rst = 1'b0; load_b = ld; en_b = e; up_b = 1'b1; lv_b = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          rst  load en   up   lv     bcd    tc   err
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h98, 8'h98, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h95, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3F, 8'h39, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h90, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h90, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0};

      rst = 1'b1; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lv_a = '0;
      en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; lv_b = '0;

      // Table: reset, carry/borrow, load priority and clamping on instance A.
      for (int i = 0; i < 17; i++) begin
         cyc_a(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
         chk($sformatf("vec%0d", i), bcd_a, tc_a, err_a, vecs[i].bcd, vecs[i].tc, vecs[i].err);
      end
      chk("b_after_reset", bcd_b, tc_b, err_b, 8'h00, 1'b0, 1'b0);

`ifdef BCD_COUNTER_SAT_EN
      // Saturation at both ends: held value, one tc per attempted step.
      cyc_a(0, 1, 0, 1, 8'h99);
      for (int k = 0; k < 3; k++) begin
         cyc_a(0, 0, 1, 1, 8'h00);
         chk($sformatf("sat_up%0d", k), bcd_a, tc_a, err_a, 8'h99, 1'b1, 1'b0);
      end
      cyc_a(0, 0, 1, 0, 8'h00);
      chk("sat_leave", bcd_a, tc_a, err_a, 8'h98, 1'b0, 1'b0);
      cyc_a(0, 1, 0, 0, 8'h00);
      cyc_a(0, 0, 1, 0, 8'h00);
      chk("sat_dn", bcd_a, tc_a, err_a, 8'h00, 1'b1, 1'b0);
      cyc_a(0, 0, 1, 1, 8'h00);
      chk("sat_dn_leave", bcd_a, tc_a, err_a, 8'h01, 1'b0, 1'b0);
`else
      // Wrap at both ends with a single-cycle tc.
      cyc_a(0, 1, 0, 1, 8'h99);
      cyc_a(0, 0, 1, 1, 8'h00);
      chk("wrap_up", bcd_a, tc_a, err_a, 8'h00, 1'b1, 1'b0);
      cyc_a(0, 0, 1, 1, 8'h00);
      chk("wrap_up_next", bcd_a, tc_a, err_a, 8'h01, 1'b0, 1'b0);
      cyc_a(0, 1, 0, 0, 8'h00);
      cyc_a(0, 0, 1, 0, 8'h00);
      chk("wrap_dn", bcd_a, tc_a, err_a, 8'h99, 1'b1, 1'b0);
      cyc_a(0, 0, 0, 0, 8'h00);
      chk("wrap_dn_hold", bcd_a, tc_a, err_a, 8'h99, 1'b0, 1'b0);
`endif
      en_a = 1'b0; load_a = 1'b0;

      // Prescaler: one step every third enabled cycle.
      for (int k = 1; k <= 9; k++) begin
         cyc_b(0, 1, 8'h00);
         chk($sformatf("pre_c%0d", k), bcd_b, tc_b, err_b, 8'(k / 3), 1'b0, 1'b0);
      end
      // Gaps in en must not lose prescaler phase.
      cyc_b(0, 1, 8'h00);
      cyc_b(0, 0, 8'h00);
      cyc_b(0, 0, 8'h00);
      chk("pre_gap", bcd_b, tc_b, err_b, 8'h03, 1'b0, 1'b0);
      cyc_b(0, 1, 8'h00);
      chk("pre_gap_pend", bcd_b, tc_b, err_b, 8'h03, 1'b0, 1'b0);
      cyc_b(0, 1, 8'h00);
      chk("pre_gap_step", bcd_b, tc_b, err_b, 8'h04, 1'b0, 1'b0);
      // Load clears the prescaler phase.
      cyc_b(0, 1, 8'h00);
      cyc_b(1, 1, 8'h50);
      chk("pre_load", bcd_b, tc_b, err_b, 8'h50, 1'b0, 1'b0);
      cyc_b(0, 1, 8'h00);
      cyc_b(0, 1, 8'h00);
      chk("pre_load_wait", bcd_b, tc_b, err_b, 8'h50, 1'b0, 1'b0);
      cyc_b(0, 1, 8'h00);
      chk("pre_load_step", bcd_b, tc_b, err_b, 8'h51, 1'b0, 1'b0);
      cyc_b(1, 0, 8'hA0);
      chk("pre_clamp", bcd_b, tc_b, err_b, 8'h90, 1'b0, 1'b1);
      // Reset mid-count discards the count.
      rst = 1'b1; en_b = 1'b1; load_b = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_reset", bcd_b, tc_b, err_b, 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
